// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: register-port responder for setup/status and a
// one-outstanding-transaction bus initiator that copies LEN words SRC -> DST.
module dma_copy (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [3:0]  dma_be_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_rdata_o,
    output logic        dma_err_o,
    output logic        host_req_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_addr_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_gnt_i,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        dma_intr_o
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    localparam logic [7:0] OFF_SRC = 8'h00, OFF_DST = 8'h01, OFF_LEN = 8'h02,
                           OFF_CTRL = 8'h03, OFF_STATUS = 8'h04, OFF_REMAIN = 8'h05;

    state_t      state;
    logic [31:0] src, dst, cur_src, cur_dst, buffer;
    logic [15:0] len, remain;
    logic        irq_en, done, err;
    logic        busy, wr, start, unmapped;
    logic [7:0]  sel;
    logic [31:0] rd_data, merged;
    logic        unused_addr;

    assign busy         = (state != IDLE);
    assign sel          = dma_addr_i[9:2];
    assign wr           = dma_req_i && dma_we_i;
    assign start        = wr && (sel == OFF_CTRL) && dma_be_i[0] && dma_wdata_i[0];
    assign dma_intr_o   = irq_en && done;
    assign host_wdata_o = buffer;
    assign unused_addr  = ^{dma_addr_i[31:10], dma_addr_i[1:0]};

    always_comb begin
        rd_data  = '0;
        unmapped = 1'b0;
        case (sel)
            OFF_SRC:    rd_data = src;
            OFF_DST:    rd_data = dst;
            OFF_LEN:    rd_data = {16'h0, len};
            OFF_CTRL:   rd_data = {30'h0, irq_en, 1'b0};
            OFF_STATUS: rd_data = {29'h0, err, done, busy};
            OFF_REMAIN: rd_data = {16'h0, remain};
            default:    unmapped = 1'b1;
        endcase
    end

    // Byte-enable merge of write data over the register's current contents.
    always_comb begin
        merged = rd_data;
        for (int b = 0; b < 4; b++)
            if (dma_be_i[b]) merged[b*8 +: 8] = dma_wdata_i[b*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            src          <= '0;
            dst          <= '0;
            len          <= '0;
            remain       <= '0;
            cur_src      <= '0;
            cur_dst      <= '0;
            buffer       <= '0;
            irq_en       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            dma_rvalid_o <= 1'b0;
            dma_rdata_o  <= '0;
            dma_err_o    <= 1'b0;
            host_req_o   <= 1'b0;
            host_we_o    <= 1'b0;
            host_be_o    <= '0;
            host_addr_o  <= '0;
        end else begin
            dma_rvalid_o <= dma_req_i;
            dma_err_o    <= dma_req_i && unmapped;
            dma_rdata_o  <= (dma_req_i && !dma_we_i) ? rd_data : '0;

            if (wr) begin
                case (sel)
                    OFF_SRC:    if (!busy) src <= {merged[31:2], 2'b00};
                    OFF_DST:    if (!busy) dst <= {merged[31:2], 2'b00};
                    OFF_LEN:    if (!busy) len <= merged[15:0];
                    OFF_CTRL:   if (dma_be_i[0]) irq_en <= dma_wdata_i[1];
                    OFF_STATUS: if (dma_be_i[0]) begin
                        if (dma_wdata_i[1]) done <= 1'b0;
                        if (dma_wdata_i[2]) err  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // FSM updates come after register writes so hardware set of done/err wins over W1C.
            case (state)
                IDLE: if (start) begin
                    if (len == 16'd0) begin
                        done <= 1'b1;
                    end else begin
                        cur_src     <= src;
                        cur_dst     <= dst;
                        remain      <= len;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        state       <= RD_REQ;
                        host_req_o  <= 1'b1;
                        host_we_o   <= 1'b0;
                        host_be_o   <= 4'hF;
                        host_addr_o <= src;
                    end
                end
                RD_REQ: if (host_gnt_i) begin
                    state      <= RD_WAIT;
                    host_req_o <= 1'b0;
                    host_be_o  <= '0;
                end
                RD_WAIT: if (host_rvalid_i) begin
                    buffer <= host_rdata_i;
                    if (host_err_i) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state       <= WR_REQ;
                        host_req_o  <= 1'b1;
                        host_we_o   <= 1'b1;
                        host_be_o   <= 4'hF;
                        host_addr_o <= cur_dst;
                    end
                end
                WR_REQ: if (host_gnt_i) begin
                    state      <= WR_WAIT;
                    host_req_o <= 1'b0;
                    host_we_o  <= 1'b0;
                    host_be_o  <= '0;
                end
                WR_WAIT: if (host_rvalid_i) begin
                    if (host_err_i) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cur_src <= cur_src + 32'd4;
                        cur_dst <= cur_dst + 32'd4;
                        remain  <= remain - 16'd1;
                        if (remain == 16'd1) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state       <= RD_REQ;
                            host_req_o  <= 1'b1;
                            host_we_o   <= 1'b0;
                            host_be_o   <= 4'hF;
                            host_addr_o <= cur_src + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register access, copies against a zero-wait bus
// responder with optional grant stalls and error injection, and reset behaviour.
module tb_dma_copy;
    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        dma_req_i = 1'b0, dma_we_i = 1'b0;
    logic [3:0]  dma_be_i = '0;
    logic [31:0] dma_addr_i = '0, dma_wdata_i = '0;
    logic        dma_rvalid_o, dma_err_o, dma_intr_o;
    logic [31:0] dma_rdata_o;
    logic        host_req_o, host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_addr_o, host_wdata_o;
    logic        host_gnt_i = 1'b0, host_rvalid_i = 1'b0, host_err_i = 1'b0;
    logic [31:0] host_rdata_i = '0;

    localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08,
                            A_CTRL = 32'h0C, A_STAT = 32'h10, A_REM = 32'h14;

    int checks = 0, errors = 0;
    int cyc = 0, t_req = -1, t_intr = -1;
    int rd_cnt = 0, wr_cnt = 0, stall_rd_n = 0, stall_wr_n = 0, stall_cycles = 0;
    int waited = 0, stall_seen = 0, err_wr_n = 0;
    bit pend = 0, pend_we = 0, pend_err = 0, in_req = 0;
    logic [31:0] pend_addr, l_addr;
    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] rd_log[$], wa_log[$], wd_log[$];

    dma_copy dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_be_i(dma_be_i),
        .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
        .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o), .dma_err_o(dma_err_o),
        .host_req_o(host_req_o), .host_we_o(host_we_o), .host_be_o(host_be_o),
        .host_addr_o(host_addr_o), .host_wdata_o(host_wdata_o),
        .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
        .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
        .dma_intr_o(dma_intr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Bus responder: grant in the request cycle unless stalled, response the next cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0;
            if (pend) begin
                host_rvalid_i = 1'b1;
                host_err_i    = pend_err;
                if (!pend_we) host_rdata_i = pat(pend_addr);
                pend = 0;
            end
            host_gnt_i = 1'b0;
            if (host_req_o) begin
                if (t_req < 0) t_req = cyc;
                if (!in_req) begin
                    in_req = 1; l_addr = host_addr_o; l_we = host_we_o; l_be = host_be_o;
                end else begin
                    checks++;
                    if ({host_addr_o, host_we_o, host_be_o} !== {l_addr, l_we, l_be}) begin
                        errors++;
                        $display("FAIL hold_stable: got %h/%b/%h need %h/%b/%h",
                                 host_addr_o, host_we_o, host_be_o, l_addr, l_we, l_be);
                    end
                end
                if ((host_we_o ? (wr_cnt + 1 == stall_wr_n) : (rd_cnt + 1 == stall_rd_n))
                    && waited < stall_cycles) begin
                    waited++; stall_seen++;
                end else begin
                    host_gnt_i = 1'b1; in_req = 0; waited = 0;
                    pend = 1; pend_we = host_we_o; pend_addr = host_addr_o; pend_err = 0;
                    if (host_we_o) begin
                        wr_cnt++; wa_log.push_back(host_addr_o); wd_log.push_back(host_wdata_o);
                        pend_err = (wr_cnt == err_wr_n);
                    end else begin
                        rd_cnt++; rd_log.push_back(host_addr_o);
                    end
                end
            end
            if (dma_intr_o && t_intr < 0) t_intr = cyc;
        end
    end

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        dma_req_i = 1'b1; dma_we_i = 1'b0; dma_be_i = 4'hF; dma_addr_i = a;
        @(negedge clk);
        dma_req_i = 1'b0;
        d = dma_rdata_o; e = dma_err_o;
        checks++;
        if (dma_rvalid_o !== 1'b1) begin
            errors++; $display("FAIL rd_rvalid @%h: got %b need 1", a, dma_rvalid_o);
        end
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        dma_req_i = 1'b1; dma_we_i = 1'b1; dma_be_i = be; dma_addr_i = a; dma_wdata_i = d;
        @(negedge clk);
        dma_req_i = 1'b0; dma_we_i = 1'b0;
        checks++;
        if ({dma_rvalid_o, dma_err_o} !== 2'b10) begin
            errors++; $display("FAIL wr_resp @%h: got rvalid/err %b%b need 10", a, dma_rvalid_o, dma_err_o);
        end
    endtask

    task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d; logic e;
        reg_rd(a, d, e);
        checks++;
        if ({d, e} !== {exp, 1'b0}) begin
            errors++; $display("FAIL %s: got %h err %b need %h err 0", name, d, e, exp);
        end
    endtask

    task automatic clear_log();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        rd_cnt = 0; wr_cnt = 0; t_req = -1; t_intr = -1; stall_seen = 0;
    endtask

    task automatic wait_done();
        logic [31:0] d; logic e;
        for (int i = 0; i < 100; i++) begin
            reg_rd(A_STAT, d, e);
            if (!d[0]) break;
        end
        checks++;
        if (d[0] !== 1'b0) begin errors++; $display("FAIL wait_done: busy still %b need 0", d[0]); end
    endtask

    task automatic check_copy(input string name, input int n, input logic [31:0] s, input logic [31:0] dd);
        checks++;
        if (rd_log.size() != n || wa_log.size() != n) begin
            errors++; $display("FAIL %s_count: got rd %0d wr %0d need %0d", name, rd_log.size(), wa_log.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if ({rd_log[i], wa_log[i], wd_log[i]} !== {s + 32'(4*i), dd + 32'(4*i), pat(s + 32'(4*i))}) begin
                    errors++;
                    $display("FAIL %s_word%0d: got rd %h wr %h data %h need %h %h %h", name, i,
                             rd_log[i], wa_log[i], wd_log[i], s + 32'(4*i), dd + 32'(4*i), pat(s + 32'(4*i)));
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o, dma_rvalid_o,
             dma_rdata_o, dma_err_o, dma_intr_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero, need all 0 (req %b addr %h)", host_req_o, host_addr_o);
        end
        rst_ni = 1'b1;
        expect_reg("reset_src", A_SRC, 0);
        expect_reg("reset_len", A_LEN, 0);
        expect_reg("reset_stat", A_STAT, 0);
        expect_reg("reset_rem", A_REM, 0);
    endtask

    task automatic test_regs();
        logic [31:0] d; logic e;
        reg_wr(A_SRC, 32'hAABBCCDD, 4'hF);
        expect_reg("src_align", A_SRC, 32'hAABBCCDC);
        reg_wr(A_SRC, 32'h11223344, 4'b0011);
        expect_reg("src_be", A_SRC, 32'hAABB3344);
        reg_wr(A_DST, 32'h00000103, 4'hF);
        expect_reg("dst_align", A_DST, 32'h00000100);
        reg_wr(A_LEN, 32'h12345678, 4'hF);
        expect_reg("len_16b", A_LEN, 32'h00005678);
        reg_wr(A_CTRL, 32'h2, 4'hF);
        expect_reg("ctrl_irq_en", A_CTRL, 32'h2);
        reg_wr(A_CTRL, 32'h0, 4'hF);
        reg_rd(32'h18, d, e);
        checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL unmapped: got %h err %b need 0 err 1", d, e); end
    endtask

    task automatic test_copy();
        clear_log();
        reg_wr(A_SRC, 32'h0010_0000, 4'hF);
        reg_wr(A_DST, 32'h0010_0400, 4'hF);
        reg_wr(A_LEN, 32'd3, 4'hF);
        reg_wr(A_CTRL, 32'h3, 4'hF);
        for (int i = 0; i < 200 && t_intr < 0; i++) @(negedge clk);
        checks++;
        if (t_intr - t_req !== 12) begin
            errors++; $display("FAIL copy_latency: got %0d cycles need 12", t_intr - t_req);
        end
        check_copy("copy", 3, 32'h0010_0000, 32'h0010_0400);
        expect_reg("copy_status", A_STAT, 32'h2);
        expect_reg("copy_remain", A_REM, 32'h0);
        reg_wr(A_STAT, 32'h2, 4'hF);
        reg_wr(A_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_zero_len();
        clear_log();
        reg_wr(A_LEN, 32'd0, 4'hF);
        reg_wr(A_CTRL, 32'h3, 4'hF);
        checks++;
        if (dma_intr_o !== 1'b1) begin errors++; $display("FAIL zero_len_intr: got %b need 1", dma_intr_o); end
        expect_reg("zero_len_status", A_STAT, 32'h2);
        reg_wr(A_STAT, 32'h2, 4'hF);
        checks++;
        if (dma_intr_o !== 1'b0) begin errors++; $display("FAIL zero_len_w1c: got %b need 0", dma_intr_o); end
        checks++;
        if (t_req !== -1) begin errors++; $display("FAIL zero_len_bus: got req at %0d need none", t_req); end
        reg_wr(A_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_stall();
        clear_log();
        stall_rd_n = 2; stall_cycles = 5;
        reg_wr(A_SRC, 32'h2000, 4'hF);
        reg_wr(A_DST, 32'h3000, 4'hF);
        reg_wr(A_LEN, 32'd2, 4'hF);
        reg_wr(A_CTRL, 32'h1, 4'hF);
        wait_done();
        check_copy("stall", 2, 32'h2000, 32'h3000);
        checks++;
        if (stall_seen !== 5) begin errors++; $display("FAIL stall_cycles: got %0d need 5", stall_seen); end
        expect_reg("stall_status", A_STAT, 32'h2);
        stall_rd_n = 0; stall_cycles = 0;
        reg_wr(A_STAT, 32'h2, 4'hF);
    endtask

    task automatic test_err();
        clear_log();
        err_wr_n = 1;
        reg_wr(A_SRC, 32'h4000, 4'hF);
        reg_wr(A_DST, 32'h5000, 4'hF);
        reg_wr(A_LEN, 32'd3, 4'hF);
        reg_wr(A_CTRL, 32'h1, 4'hF);
        wait_done();
        expect_reg("err_status", A_STAT, 32'h4);
        expect_reg("err_remain", A_REM, 32'd3);
        checks++;
        if (wr_cnt !== 1) begin errors++; $display("FAIL err_writes: got %0d need 1", wr_cnt); end
        err_wr_n = 0;
        reg_wr(A_STAT, 32'h4, 4'hF);
        expect_reg("err_w1c", A_STAT, 32'h0);
    endtask

    task automatic test_wrap();
        clear_log();
        reg_wr(A_SRC, 32'hFFFF_FFFC, 4'hF);
        reg_wr(A_DST, 32'h6000, 4'hF);
        reg_wr(A_LEN, 32'd2, 4'hF);
        reg_wr(A_CTRL, 32'h1, 4'hF);
        reg_wr(A_LEN, 32'd7, 4'hF);
        reg_wr(A_SRC, 32'h10, 4'hF);
        wait_done();
        check_copy("wrap", 2, 32'hFFFF_FFFC, 32'h6000);
        expect_reg("wrap_len_kept", A_LEN, 32'd2);
        expect_reg("wrap_src_kept", A_SRC, 32'hFFFF_FFFC);
        reg_wr(A_STAT, 32'h2, 4'hF);
    endtask

    task automatic test_reset_mid();
        clear_log();
        stall_wr_n = 1; stall_cycles = 20;
        reg_wr(A_SRC, 32'h7000, 4'hF);
        reg_wr(A_DST, 32'h8000, 4'hF);
        reg_wr(A_LEN, 32'd2, 4'hF);
        reg_wr(A_CTRL, 32'h3, 4'hF);
        for (int i = 0; i < 50 && !(host_req_o && host_we_o); i++) @(negedge clk);
        checks++;
        if ({host_req_o, host_we_o} !== 2'b11) begin errors++; $display("FAIL mid_wr_req: got %b%b need 11", host_req_o, host_we_o); end
        rst_ni = 1'b0;
        @(negedge clk);
        checks++;
        if ({host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o, dma_intr_o} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got req %b addr %h wdata %h need 0", host_req_o, host_addr_o, host_wdata_o);
        end
        rst_ni = 1'b1;
        stall_wr_n = 0; stall_cycles = 0; waited = 0; in_req = 0;
        expect_reg("mid_src", A_SRC, 0);
        expect_reg("mid_dst", A_DST, 0);
        expect_reg("mid_len", A_LEN, 0);
        expect_reg("mid_ctrl", A_CTRL, 0);
        expect_reg("mid_status", A_STAT, 0);
        expect_reg("mid_remain", A_REM, 0);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_copy();
        test_zero_len();
        test_stall();
        test_err();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
